// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM initiator: arbitrates write/read requests onto one port,
// returns read data in order through a credit-protected FWFT response FIFO.
module sram_sp_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned LAYER_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  cs,
  output logic                  we,
  output logic                  oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  layer_done
);

  localparam int unsigned CRD_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned LYR_W = (LAYER_WORDS > 1) ? $clog2(LAYER_WORDS) : 1;

  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [LYR_W-1:0] LYR_LAST = LYR_W'(LAYER_WORDS - 1);

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e                 prio_q, prio_d;
  logic [CRD_W-1:0]      credit_q, credit_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  cap_q, cap_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CRD_W-1:0]      cnt_q, cnt_d;
  logic [LYR_W-1:0]      lyr_q, lyr_d;
  logic                  layer_done_q, layer_done_d;

  logic rd_elig;
  logic contested;
  logic wr_acc;
  logic rd_acc;
  logic rsp_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and arbitration: the side holding priority blocks the other only when both compete
  always_comb begin
    rd_elig   = rd_valid && (credit_q < CRD_MAX);
    contested = wr_valid && rd_elig;
    wr_ready  = !rst && !(rd_elig && (prio_q == PRIO_RD));
    rd_ready  = !rst && (credit_q < CRD_MAX) && !(wr_valid && (prio_q == PRIO_WR));
    wr_acc    = wr_valid && wr_ready;
    rd_acc    = rd_valid && rd_ready;
    rsp_valid = (cnt_q != '0);
    rsp_data  = rsp_valid ? mem_q[rptr_q] : '0;
    rsp_pop   = rsp_valid && rsp_ready;
  end

  // Next-state logic for pins, read-capture pipeline, FIFO, credits and layer counter
  always_comb begin
    prio_d       = prio_q;
    credit_d     = credit_q + CRD_W'(rd_acc) - CRD_W'(rsp_pop);
    cs_d         = wr_acc || rd_acc;
    we_d         = wr_acc;
    oe_d         = rd_acc;
    addr_d       = addr_q;
    din_d        = din_q;
    cap_d        = cs_q && oe_q;
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q + CRD_W'(cap_q) - CRD_W'(rsp_pop);
    lyr_d        = lyr_q;
    layer_done_d = 1'b0;

    if (contested) begin
      prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end

    if (wr_acc) begin
      addr_d = wr_addr;
      din_d  = wr_data;
      if (lyr_q == LYR_LAST) begin
        lyr_d        = '0;
        layer_done_d = 1'b1;
      end else begin
        lyr_d = lyr_q + LYR_W'(1);
      end
    end else if (rd_acc) begin
      addr_d = rd_addr;
    end

    // dout is valid the cycle after the read access; capture it into the FIFO tail
    if (cap_q) begin
      mem_d[wptr_q] = dout;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (rsp_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      prio_q       <= PRIO_WR;
      credit_q     <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      oe_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      cap_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      lyr_q        <= '0;
      layer_done_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      credit_q     <= credit_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      oe_q         <= oe_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      cap_q        <= cap_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      lyr_q        <= lyr_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign cs         = cs_q;
  assign we         = we_q;
  assign oe         = oe_q;
  assign addr       = addr_q;
  assign din        = din_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Bench for sram_sp_ctrl: SRAM model on the pins, transaction-level reference
// model (memory image, response queue with ready times, layer count) checked every cycle.
module tb_sram_sp_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          cs, we, oe;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          layer_done;

  sram_sp_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (DEPTH),
    .LAYER_WORDS(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .cs        (cs),
    .we        (we),
    .oe        (oe),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data appears the cycle after the access
  logic [DW-1:0] sram [2**AW];
  always @(posedge clk) begin
    if (cs && we) sram[addr] <= din;
    if (cs && oe) dout <= sram[addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [2**AW];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            prio_rd = 1'b0;
  int            lcount = 0;
  int            exp_kind = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  bit            exp_ld = 1'b0;
  bit            rst_prev = 1'b1;
  int            ld_seen = 0;
  int            rsp_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    chk("cs", 32'(cs), 32'(exp_kind != 0));
    chk("we", 32'(we), 32'(exp_kind == 1));
    chk("oe", 32'(oe), 32'(exp_kind == 2));
    chk("addr", 32'(addr), 32'(exp_addr));
    chk("din", 32'(din), 32'(exp_din));
    chk("layer_done", 32'(layer_done), 32'(exp_ld));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
    if (rst_prev) chk("rsp_data_rst", 32'(rsp_data), 32'(0));
    if (layer_done) ld_seen++;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check handshakes, advance the model
  task automatic cycle(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra, input bit rr,
                       output bit wacc, output bit racc);
    int credit;
    bit elig;
    bit pr;
    int win;
    @(negedge clk);
    cyc++;
    check_outputs();
    rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rsp_ready = rr;
    #1;
    wacc = wv && wr_ready;
    racc = rv && rd_ready;
    if (r) begin
      chk("wr_ready_rst", 32'(wr_ready), 32'(0));
      chk("rd_ready_rst", 32'(rd_ready), 32'(0));
      exp_q.delete();
      prio_rd = 1'b0; lcount = 0; exp_kind = 0;
      exp_addr = '0; exp_din = '0; exp_ld = 1'b0; rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      credit = exp_q.size();
      elig = rv && (credit < int'(DEPTH));
      pr = prio_rd;
      win = 0;
      if (wv && elig) begin
        win = pr ? 2 : 1;
        prio_rd = !pr;
      end else if (wv) win = 1;
      else if (elig) win = 2;
      chk("wr_ready", 32'(wr_ready), 32'(!(elig && pr)));
      chk("rd_ready", 32'(rd_ready), 32'((credit < int'(DEPTH)) && !(wv && !pr)));
      chk("wr_grant", 32'(wacc), 32'(win == 1));
      chk("rd_grant", 32'(racc), 32'(win == 2));
      if (exp_q.size() > 0 && exp_q[0].avail <= cyc && rr) begin
        void'(exp_q.pop_front());
        rsp_seen++;
      end
      exp_ld = 1'b0;
      if (win == 1) begin
        ref_mem[wa] = wd;
        lcount++;
        if (lcount == int'(LW)) begin
          lcount = 0;
          exp_ld = 1'b1;
        end
        exp_kind = 1; exp_addr = wa; exp_din = wd;
      end else if (win == 2) begin
        exp_q.push_back('{ref_mem[ra], cyc + 3});
        exp_kind = 2; exp_addr = ra;
      end else begin
        exp_kind = 0;
      end
    end
  endtask

  task automatic idle(input int n, input bit rr);
    bit wa, ra;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, rr, wa, ra);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wa, ra;
    int issued, base, prev_w;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;

    // Reset held with random requests
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), wa, ra);
    idle(2, 1'b1);

    // Fill the whole SRAM so every later read has a known value
    for (int a = 0; a < 2**AW; a++)
      cycle(1'b0, 1'b1, 8'(a), 8'($urandom), 1'b0, '0, 1'b1, wa, ra);
    idle(3, 1'b1);

    // Write then read-back to the same address
    cycle(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, '0, 1'b0, wa, ra);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'h10, 1'b0, wa, ra);
    chk("raw_rd_accept", 32'(ra), 32'(1));
    idle(2, 1'b0);
    chk("raw_latency_early", 32'(rsp_valid), 32'(0));
    idle(1, 1'b0);
    chk("raw_latency", 32'(rsp_valid), 32'(1));
    chk("raw_data", 32'(rsp_data), 32'(8'hA5));
    idle(3, 1'b1);

    // Back-pressured responses: credits cap reads in flight
    issued = 0;
    base = rsp_seen;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, '0, '0, issued < 6, 8'(32 + issued), 1'b0, wa, ra);
      if (ra) issued++;
    end
    chk("bp_accepted", 32'(issued), 32'(4));
    chk("bp_rd_ready_low", 32'(rd_ready), 32'(0));
    for (int i = 0; i < 40 && (issued < 6 || exp_q.size() > 0); i++) begin
      cycle(1'b0, 1'b0, '0, '0, issued < 6, 8'(32 + issued), 1'b1, wa, ra);
      if (ra) issued++;
    end
    chk("bp_all_accepted", 32'(issued), 32'(6));
    chk("bp_responses", 32'(rsp_seen - base), 32'(6));
    idle(2, 1'b1);

    // Contested requests alternate grants
    prev_w = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'(64 + i), 8'($urandom), 1'b1, 8'(64 + i), 1'b1, wa, ra);
      chk("one_grant", 32'(int'(wa) + int'(ra)), 32'(1));
      if (i > 0) chk("alternate", 32'(int'(wa)), 32'(1 - prev_w));
      prev_w = int'(wa);
    end
    idle(5, 1'b1);

    // Layer pulses on the 4th and 8th of 9 writes
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, wa, ra);
    ld_seen = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, 8'(96 + i), 8'($urandom), 1'b0, '0, 1'b1, wa, ra);
      idle(i % 3, 1'b1);
    end
    idle(2, 1'b1);
    chk("layer_pulses", 32'(ld_seen), 32'(2));

    // Reset with reads in flight, then verify full credit is available again
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'h05, 1'b0, wa, ra);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'h06, 1'b0, wa, ra);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, wa, ra);
    idle(6, 1'b1);
    issued = 0;
    base = rsp_seen;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, '0, '0, issued < 5, 8'(issued), 1'b0, wa, ra);
      if (ra) issued++;
    end
    chk("post_rst_credit", 32'(issued), 32'(4));
    idle(8, 1'b1);
    chk("post_rst_responses", 32'(rsp_seen - base), 32'(4));

    // Random traffic, small address window for read-after-write hits
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(299) == 0, 1'($urandom), 8'($urandom_range(15)), 8'($urandom),
            1'($urandom), 8'($urandom_range(15)), $urandom_range(9) < 7, wa, ra);
    idle(10, 1'b1);
    chk("final_drain", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
